triad_encoder: RTL and testbench
================================

# triad_encoder

Eight-channel distrip triad serializer for the comparator test stand. Takes a 32-bit half-strip hit pattern and transmits one 3-bit serial triad per distrip on `distrip_out[7:0]`, in lockstep, at 40 MHz. It is the transmit end of the triad link whose receive end is the per-distrip `triad_decode` instances. Its uses are loopback self-test of the decoders and injection of known patterns into downstream logic.

## Interface
- `GAP`, default 2: minimum idle cycles after the last triad bit before a new `start` is accepted; legal range 0..15.
- `clock40`  in  1: 40 MHz system clock; all logic on the rising edge.
- `reset`  in  1: synchronous reset, active-high.
- `halfstrips_in`  in  32: hit pattern; bits [4k+3:4k] belong to distrip k.
- `start`  in  1: single-cycle request; sampled only when `ready`=1.
- `ready`  out  1: high in IDLE; reset value 1.
- `distrip_out`  out  8: serial triad stream per distrip, registered; reset value 0.
- `multihit`  out  8: one-cycle pulse, distrip group had more than one bit set; reset value 0.
- `done`  out  1: one-cycle pulse on the last triad bit; reset value 0.
- `errcnt`  out  32: present only with `TRIAD_ENC_ERRCNT_EN`; reset value 0.
- `errcnt_rst`  in  1: present only with `TRIAD_ENC_ERRCNT_EN`; synchronous clear of `errcnt`.

## Operation
- **Encoding per distrip group `g = halfstrips_in[4k+3:4k]`.**
  - Index `i` is the lowest set bit of `g`.
  - Triad bits, sent in order: `1`, `i[1]`, `i[0]`.
  - Resulting map: `0001`→100, `0010`→101, `0100`→110, `1000`→111.
  - If `g==0`, the channel drives 0 for all three bits.
- **Multihit.** If `g` has two or more bits set, the lowest set bit still wins and `multihit[k]` pulses.
- **FSM states:** IDLE → BIT0 → BIT1 → BIT2 → GAP → IDLE.
  - IDLE: `ready`=1. `start`=1 latches `halfstrips_in`, pre-loads the per-channel 3-bit shift registers, and moves to BIT0.
  - BIT0, BIT1, BIT2: one triad bit per cycle. BIT2 asserts `done`.
  - GAP: counts `GAP` cycles. With `GAP`=0, BIT2 goes directly to IDLE.
- **Ignored start.** `start` while `ready`=0 is ignored. No queueing takes place.
- **Reset mid-operation.** The triad is aborted. The state returns to IDLE, `distrip_out`=0 in the next cycle, and no `done` is issued.
- **Independence.** `halfstrips_in` changes after acceptance have no effect on the triad in flight.

## Timing
- `start` is sampled at edge N.
- `distrip_out` carries bit0 in cycle N+1, bit1 in N+2, bit2 in N+3.
- `multihit` is valid in cycle N+1. `done` is high in cycle N+3.
- `ready` returns high in cycle N+4+GAP. A back-to-back start is legal at edge N+4+GAP.
- Throughput: one pattern per 4+GAP cycles.
- `distrip_out` is glitch-free because it is driven straight from flops.

## Configuration
- **`TRIAD_ENC_ERRCNT_EN` defined:** `errcnt`/`errcnt_rst` exist.
  - `errcnt` increments by 1 for each accepted start that has any multihit.
  - It also increments by 1 for each ignored start.
  - If both conditions occur in the same cycle, it still increments by only 1.
  - It saturates at 0xFFFF_FFFF. `errcnt_rst` takes priority over increment.
- **Undefined:** neither port exists and no counter logic is synthesized. All other behaviour is identical.

## Structure
- **Shared package `triad_pkg`:**
  - `TRIAD_LEN`=3, `N_DISTRIP`=8, `HS_PER_DS`=4.
  - State enum {IDLE, BIT0, BIT1, BIT2, GAP}.
  - Function `triad_bits(g)` returning the 3-bit triad plus a multihit flag. The package is shared with `triad_decode` tests.
- **Sub-module `triad_encode_ch`:** one channel, containing the priority encoder, 3-bit shift register and multihit flag. It is instantiated 8× under a generate loop, with one shared FSM and GAP counter in the top.

## Test plan
- Start with 0x0000_0001 → `distrip_out[0]`=1,0,0 in N+1..N+3, other channels 0, `done` at N+3, `ready` at N+6 (GAP=2).
- Start with 0x8000_0000 → `distrip_out[7]`=1,1,1, `multihit`=0.
- Start with 0x0000_0006 → `distrip_out[0]`=1,0,1, `multihit[0]` pulses at N+1, `errcnt`=1 (macro on).
- GAP=2: start at N, start at N+4 ignored (`errcnt`+1), start at N+6 accepted, triad at N+7..N+9.
- Start at N, `reset` at edge N+2 → `distrip_out`=0 from N+3, no `done`, `ready`=1 at N+3.
- Loopback into 8 `triad_decode` with pattern 0x8421_1248 → decoded halfstrips equal 0x8421_1248, no triad skips.

Source files
------------

// File: rtl/triad_pkg.sv
// Shared triad link definitions: sizes, encoder state enum and the per-distrip
// triad encoding function used by both the encoder and the decoder tests.
package triad_pkg;

  localparam int TRIAD_LEN = 3;
  localparam int N_DISTRIP = 8;
  localparam int HS_PER_DS = 4;
  localparam int HS_WIDTH  = N_DISTRIP * HS_PER_DS;

  // The gap state is GAP_WAIT so it cannot collide with the GAP parameter.
  typedef enum logic [2:0] {
    IDLE,
    BIT0,
    BIT1,
    BIT2,
    GAP_WAIT
  } triad_state_t;

  typedef struct packed {
    logic [TRIAD_LEN-1:0] bits;
    logic                 multihit;
  } triad_t;

  // Lowest set half-strip wins; triad is {1, idx[1], idx[0]}, all-zero when empty.
  function automatic triad_t triad_bits(input logic [HS_PER_DS-1:0] g);
    triad_t     t;
    logic [1:0] idx;
    logic [2:0] cnt;
    t   = '0;
    idx = '0;
    cnt = '0;
    for (int b = HS_PER_DS - 1; b >= 0; b--) begin
      if (g[b]) begin
        idx = 2'(b);
        cnt = cnt + 3'd1;
      end
    end
    if (g != '0) begin
      t.bits = {1'b1, idx};
    end
    t.multihit = (cnt > 3'd1);
    return t;
  endfunction

endpackage

// File: rtl/triad_encode_ch.sv
// One distrip channel: priority encoder, 3-bit triad shift register and
// multihit pulse. The serial output is taken straight from the register MSB.
module triad_encode_ch
  import triad_pkg::*;
(
  input  logic                 clock40,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 shift,
  input  logic [HS_PER_DS-1:0] group,
  output logic                 serial,
  output logic                 multihit
);

  triad_t               enc;
  logic [TRIAD_LEN-1:0] sr_reg;
  logic                 mh_reg;

  assign enc = triad_bits(group);

  always_ff @(posedge clock40) begin
    if (reset) begin
      sr_reg <= '0;
      mh_reg <= 1'b0;
    end else begin
      mh_reg <= 1'b0;
      if (load) begin
        sr_reg <= enc.bits;
        mh_reg <= enc.multihit;
      end else if (shift) begin
        // Shifting on the last bit empties the register, returning the line to 0.
        sr_reg <= {sr_reg[TRIAD_LEN-2:0], 1'b0};
      end
    end
  end

  assign serial   = sr_reg[TRIAD_LEN-1];
  assign multihit = mh_reg;

endmodule

// File: rtl/triad_encoder.sv
// Eight-channel distrip triad serializer with one shared sequencing FSM.
// Optional error counter ports are enabled by defining TRIAD_ENC_ERRCNT_EN.
module triad_encoder
  import triad_pkg::*;
#(
  parameter int unsigned GAP = 2
)
(
  input  logic                 clock40,
  input  logic                 reset,
  input  logic [HS_WIDTH-1:0]  halfstrips_in,
  input  logic                 start,
`ifdef TRIAD_ENC_ERRCNT_EN
  input  logic                 errcnt_rst,
  output logic [31:0]          errcnt,
`endif
  output logic                 ready,
  output logic [N_DISTRIP-1:0] distrip_out,
  output logic [N_DISTRIP-1:0] multihit,
  output logic                 done
);

  localparam logic [3:0] GAP_M1 = 4'((GAP == 0) ? 0 : GAP - 1);

  triad_state_t state_reg;
  logic [3:0]   gap_cnt_reg;
  logic         ready_reg;
  logic         done_reg;
  logic         load;
  logic         shift;

  assign load  = (state_reg == IDLE) && start;
  assign shift = (state_reg == BIT0) || (state_reg == BIT1) || (state_reg == BIT2);

  always_ff @(posedge clock40) begin
    if (reset) begin
      state_reg   <= IDLE;
      gap_cnt_reg <= '0;
      ready_reg   <= 1'b1;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg <= BIT0;
            ready_reg <= 1'b0;
          end
        end
        BIT0: state_reg <= BIT1;
        BIT1: begin
          state_reg <= BIT2;
          done_reg  <= 1'b1;
        end
        BIT2: begin
          if (GAP == 0) begin
            state_reg <= IDLE;
            ready_reg <= 1'b1;
          end else begin
            state_reg   <= GAP_WAIT;
            gap_cnt_reg <= GAP_M1;
          end
        end
        GAP_WAIT: begin
          if (gap_cnt_reg == 4'd0) begin
            state_reg <= IDLE;
            ready_reg <= 1'b1;
          end else begin
            gap_cnt_reg <= gap_cnt_reg - 4'd1;
          end
        end
        default: begin
          state_reg <= IDLE;
          ready_reg <= 1'b1;
        end
      endcase
    end
  end

  assign ready = ready_reg;
  assign done  = done_reg;

  generate
    for (genvar gi = 0; gi < N_DISTRIP; gi++) begin : g_ch
      triad_encode_ch u_ch (
        .clock40  (clock40),
        .reset    (reset),
        .load     (load),
        .shift    (shift),
        .group    (halfstrips_in[gi*HS_PER_DS +: HS_PER_DS]),
        .serial   (distrip_out[gi]),
        .multihit (multihit[gi])
      );
    end
  endgenerate

`ifdef TRIAD_ENC_ERRCNT_EN
  logic [N_DISTRIP-1:0] mh_now;
  logic                 err_event;
  logic [31:0]          errcnt_reg;

  generate
    for (genvar gi = 0; gi < N_DISTRIP; gi++) begin : g_mh
      triad_t enc_now;
      assign enc_now    = triad_bits(halfstrips_in[gi*HS_PER_DS +: HS_PER_DS]);
      assign mh_now[gi] = enc_now.multihit;
    end
  endgenerate

  // A multihit accept and an ignored start are one error event, never two.
  assign err_event = (load && (|mh_now)) || (start && (state_reg != IDLE));

  always_ff @(posedge clock40) begin
    if (reset || errcnt_rst) begin
      errcnt_reg <= '0;
    end else if (err_event && (errcnt_reg != 32'hFFFF_FFFF)) begin
      errcnt_reg <= errcnt_reg + 32'd1;
    end
  end

  assign errcnt = errcnt_reg;
`endif

endmodule

// File: tb/tb_triad_encoder.sv
// Self-checking bench for triad_encoder: directed scenarios plus random
// patterns, checked against a lowest-set-bit reference and a serial decoder.
module tb_triad_encoder;

  localparam int GAP = 2;

  logic        clock40 = 1'b0;
  logic        reset;
  logic [31:0] halfstrips_in;
  logic        start;
  logic        ready;
  logic [7:0]  distrip_out;
  logic [7:0]  multihit;
  logic        done;
`ifdef TRIAD_ENC_ERRCNT_EN
  logic        errcnt_rst;
  logic [31:0] errcnt;
`endif

  int checks = 0;
  int errors = 0;
  int unsigned err_model = 0;

  triad_encoder #(.GAP(GAP)) dut (
    .clock40       (clock40),
    .reset         (reset),
    .halfstrips_in (halfstrips_in),
    .start         (start),
`ifdef TRIAD_ENC_ERRCNT_EN
    .errcnt_rst    (errcnt_rst),
    .errcnt        (errcnt),
`endif
    .ready         (ready),
    .distrip_out   (distrip_out),
    .multihit      (multihit),
    .done          (done)
  );

  always #5 clock40 = ~clock40;

  task automatic step();
    @(posedge clock40);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: triad value is 4 + index of lowest set bit, 0 for an empty group.
  function automatic logic [2:0] ref_triad(input logic [3:0] g);
    int i;
    if (g == 4'd0) return 3'd0;
    i = 0;
    while (!g[i]) i++;
    return 3'(4 + i);
  endfunction

  task automatic check_errcnt(input string tag);
`ifdef TRIAD_ENC_ERRCNT_EN
    chk(tag, errcnt, err_model);
`else
    if (tag.len() == 0) $display("unnamed errcnt check");
`endif
  endtask

  // Sends one pattern with start sampled at edge N; checks cycles N+1..N+4+GAP.
  task automatic run_triad(input logic [31:0] pat, input bit noise);
    logic [7:0]  exp_b [3];
    logic [7:0]  got_b [3];
    logic [7:0]  exp_mh;
    logic [2:0]  t;
    logic [31:0] dec;
    logic [31:0] iso;
    logic [3:0]  g;
    exp_mh = '0;
    for (int k = 0; k < 8; k++) begin
      g = pat[4*k +: 4];
      t = ref_triad(g);
      exp_b[0][k] = t[2];
      exp_b[1][k] = t[1];
      exp_b[2][k] = t[0];
      exp_mh[k]   = ($countones(g) > 1);
    end
    if (exp_mh != 8'd0) err_model++;
    halfstrips_in = pat;
    start = 1'b1;
    step();
    for (int c = 0; c <= 3 + GAP; c++) begin
      start = 1'b0;
      if (c < 3) begin
        got_b[c] = distrip_out;
        chk($sformatf("bit%0d pat=%08h", c, pat), distrip_out, exp_b[c]);
      end else begin
        chk($sformatf("idle_line c=%0d pat=%08h", c, pat), distrip_out, 8'd0);
      end
      chk($sformatf("multihit c=%0d pat=%08h", c, pat), multihit, (c == 0) ? exp_mh : 8'd0);
      chk($sformatf("done c=%0d pat=%08h", c, pat), done, (c == 2));
      chk($sformatf("ready c=%0d pat=%08h", c, pat), ready, (c == 3 + GAP));
      if (c < 3 + GAP) begin
        halfstrips_in = $urandom;
        if (noise && ($urandom_range(0, 3) == 0)) begin
          start = 1'b1;
          err_model++;
        end
        step();
      end
    end
    start = 1'b0;
    check_errcnt($sformatf("errcnt pat=%08h", pat));
    // Loopback decode of the captured serial stream.
    dec = '0;
    iso = '0;
    for (int k = 0; k < 8; k++) begin
      g = pat[4*k +: 4];
      iso[4*k +: 4] = g & (~g + 4'd1);
      if (got_b[0][k]) dec[4*k +: 4] = 4'(1 << (2 * got_b[1][k] + got_b[2][k]));
    end
    chk($sformatf("loopback pat=%08h", pat), dec, iso);
    $display("triad pat=%08h sent, multihit=%02h", pat, exp_mh);
  endtask

  initial begin
    logic [31:0] p;
    reset = 1'b1;
    start = 1'b0;
    halfstrips_in = '0;
`ifdef TRIAD_ENC_ERRCNT_EN
    errcnt_rst = 1'b0;
`endif
    step();
    step();
    reset = 1'b0;
    chk("reset_ready", ready, 1'b1);
    chk("reset_distrip", distrip_out, 8'd0);
    chk("reset_multihit", multihit, 8'd0);
    chk("reset_done", done, 1'b0);
    check_errcnt("reset_errcnt");
    step();
    chk("idle_done", done, 1'b0);

    run_triad(32'h0000_0001, 1'b0);
    run_triad(32'h8000_0000, 1'b0);
    run_triad(32'h0000_0006, 1'b0);
    run_triad(32'h8421_1248, 1'b0);

    // Start at N accepted, start at N+4 ignored, start at N+6 accepted.
    halfstrips_in = 32'h0000_0010;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    chk("gap_done_n3", done, 1'b1);
    step();
    halfstrips_in = 32'hFFFF_FFFF;
    start = 1'b1;
    err_model++;
    step();
    start = 1'b0;
    chk("ignored_distrip", distrip_out, 8'd0);
    chk("ignored_multihit", multihit, 8'd0);
    chk("ignored_ready", ready, 1'b0);
    step();
    chk("ready_n6", ready, 1'b1);
    check_errcnt("errcnt_ignored");
    $display("ignored start at N+4 checked");
    run_triad(32'h0000_0040, 1'b0);

    // Reset at edge N+2 aborts the triad.
    halfstrips_in = 32'h8421_1248;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    err_model = 0;
    chk("abort_distrip", distrip_out, 8'd0);
    chk("abort_done", done, 1'b0);
    chk("abort_ready", ready, 1'b1);
    chk("abort_multihit", multihit, 8'd0);
    check_errcnt("abort_errcnt");
    step();
    chk("abort_done2", done, 1'b0);
    chk("abort_distrip2", distrip_out, 8'd0);
    $display("reset mid-triad checked");

    for (int n = 0; n < 12; n++) begin
      p = '0;
      for (int k = 0; k < 8; k++) begin
        if ($urandom_range(0, 4) != 0) p[4*k +: 4] = 4'(1 << $urandom_range(0, 3));
      end
      run_triad(p, 1'b1);
    end
    for (int n = 0; n < 12; n++) begin
      run_triad($urandom, 1'b1);
    end

`ifdef TRIAD_ENC_ERRCNT_EN
    errcnt_rst = 1'b1;
    step();
    errcnt_rst = 1'b0;
    err_model = 0;
    check_errcnt("errcnt_clear");
    $display("errcnt clear checked");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
